// File: rtl/nibble_serial_adder_ctrl_if.sv
// rtl/nibble_serial_adder_ctrl_if.sv - start/done request bus for the nibble-serial adder.
// The sub signal exists only when SUBTRACT_EN is defined.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUBTRACT_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
`ifdef SUBTRACT_EN
        output sub,
`endif
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SUBTRACT_EN
        input  sub,
`endif
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - W-bit add on one 4-bit slice, one nibble per clock, LSB first.
// Optional SUBTRACT_EN macro adds a sub select (a - b via ~b and forced carry-in).
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic            sub_sel;
    logic [W-1:0]    b_in;
    logic            c_in;
    logic [4:0]      nib_sum;
    logic            last;

`ifdef SUBTRACT_EN
    assign sub_sel = bus.sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign b_in = sub_sel ? ~bus.b : bus.b;
    assign c_in = sub_sel ? 1'b1 : bus.cin;

    // Operand registers shift right each cycle, so the active nibble is always [3:0].
    assign nib_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign last    = (idx_q == IW'(NIBBLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == IDLE && bus.start) begin
            a_d     = bus.a;
            b_d     = b_in;
            carry_d = c_in;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = nib_sum[4];
            idx_d   = last ? '0 : idx_q + IW'(1);
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IW'(n)) sum_d[4*n +: 4] = nib_sum[3:0];
            end
            if (last) begin
                cout_d = nib_sum[4];
                ovf_d  = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = done_q;
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovf  = ovf_q;
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - directed bench with an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus ();
    nibble_serial_adder_ctrl_if #(.NIBBLES(1))   bus1 ();

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut  (.clk(clk), .rst(rst), .bus(bus));
    nibble_serial_adder_ctrl #(.NIBBLES(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole-word arithmetic plus a cycle countdown to done.
    logic         m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;
    int           rem = 0;

    task automatic model_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                            input logic s);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         c0;
        longint       tot, lim;
        be   = s ? ~bv : bv;
        c0   = s ? 1'b1 : c;
        full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c0};
        tot  = longint'($signed(av)) + longint'($signed(be)) + longint'(c0);
        lim  = longint'(1) << (W - 1);
        p_sum  = full[W-1:0];
        p_cout = full[W];
        p_ovf  = (tot >= lim) || (tot < -lim);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_sum = '0;
            m_cout = 1'b0; m_ovf = 1'b0; rem = 0;
        end else begin
            m_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
                end
            end else if (bus.start) begin
`ifdef SUBTRACT_EN
                model_op(bus.a, bus.b, bus.cin, bus.sub);
`else
                model_op(bus.a, bus.b, bus.cin, 1'b0);
`endif
                rem    = NIB;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_busy", bus.busy, m_busy);
            chk("mdl_done", bus.done, m_done);
            if (!m_busy) chk("mdl_sum", bus.sum, m_sum);
            chk("mdl_cout", bus.cout, m_cout);
            chk("mdl_ovf", bus.ovf, m_ovf);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic s, input logic [W-1:0] es,
                         input logic ec, input logic eo);
        int n;
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.cin = c; bus.start = 1'b1;
`ifdef SUBTRACT_EN
        bus.sub = s;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_busy"}, bus.busy, 1'b1);
        bus.a = ~av; bus.b = ~bv; bus.cin = ~c;
        wait_done(n);
        chk({nm, "_lat"}, n, NIB);
        chk({nm, "_sum"}, bus.sum, es);
        chk({nm, "_cout"}, bus.cout, ec);
        chk({nm, "_ovf"}, bus.ovf, eo);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub = 1'b0; bus1.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_sum", bus.sum, 16'h0000);
        chk("rst_cout", bus.cout, 1'b0);
        rst = 1'b0;

        do_op("add1", 16'h4B2F, 16'h19D3, 1'b0, 1'b0, 16'h6502, 1'b0, 1'b0);
        do_op("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Back-to-back: start stays high; operands change after the first accept.
        @(negedge clk);
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h1111;
        wait_done(n);
        chk("b2b1_lat", n, NIB);
        chk("b2b1_sum", bus.sum, 16'h0003);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b2_busy", bus.busy, 1'b1);
        wait_done(n);
        chk("b2b2_lat", n, NIB);
        chk("b2b2_sum", bus.sum, 16'h2345);

        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Mid-run async reset discards the operation.
        @(negedge clk);
        bus.a = 16'h7777; bus.b = 16'h1111; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_sum", bus.sum, 16'h0000);
        chk("arst_cout", bus.cout, 1'b0);
        chk("arst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_op("post_rst", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
        do_op("sub1", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        do_op("sub2", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
`endif

        // Single-nibble instance: RUN lasts one cycle.
        @(negedge clk);
        bus1.a = 4'h9; bus1.b = 4'h8; bus1.cin = 1'b0; bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk("n1_busy", bus1.busy, 1'b1);
        chk("n1_done0", bus1.done, 1'b0);
        @(negedge clk);
        chk("n1_done", bus1.done, 1'b1);
        chk("n1_busy0", bus1.busy, 1'b0);
        chk("n1_sum", bus1.sum, 4'h1);
        chk("n1_cout", bus1.cout, 1'b1);
        chk("n1_ovf", bus1.ovf, 1'b1);
        @(negedge clk);
        chk("n1_done_clr", bus1.done, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
